mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the 5-stage pipeline, including the MEM/WB pipeline register. It consumes the EX/MEM register outputs (ALU result, store data, width, sign, control) and performs loads and stores with byte, half and word width against a synchronous byte-enabled data memory. It presents write-back-ready data, the destination register and control bits one cycle later. Stores write to memory at the clock edge; loads return aligned, sign- or zero-extended data.

## Interface
- NB_DATA, 32, datapath width
- NB_REG, 5, register index width
- NB_ADDR, 8, word-address bits (memory depth 2^NB_ADDR words); byte address = i_result[NB_ADDR+1:0]
- clk  in  1  clock; everything on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_halt  in  1  freeze: no memory write, no register update
- i_mem2reg  in  1  write-back selects memory data
- i_memWrite  in  1  store request
- i_regWrite  in  1  register-file write enable
- i_width  in  2  00 byte, 01 half, 11 word; 10 treated as word
- i_sign_flag  in  1  1 = sign-extend load, 0 = zero-extend
- i_result  in  NB_DATA  ALU result / byte address
- i_data4Mem  in  NB_DATA  store data
- i_write_reg  in  NB_REG  destination register
- o_mem2reg, o_regWrite  out  1 each  registered control
- o_read_data  out  NB_DATA  extended load data
- o_result  out  NB_DATA  registered ALU result
- o_write_reg  out  NB_REG  registered destination
- o_misalign  out  1  one-cycle flag for the access just registered
- i_dbg_addr  in  NB_ADDR  debug word address (MEM_DEBUG_PORT_EN only)
- o_dbg_data  out  NB_DATA  debug word readback (MEM_DEBUG_PORT_EN only)

## Operation
- Little-endian. Word index = i_result[NB_ADDR+1:2]; byte offset = i_result[1:0].
- Misaligned access: half with offset[0]=1, or word with offset≠0.
  - Store is suppressed.
  - Load data forced to 0.
  - o_misalign=1 for that cycle.
  - Only evaluated when i_memWrite or i_mem2reg is set.
- Store byte enables:
  - Byte: one lane at the offset; lane data = i_data4Mem[7:0] replicated across all four lanes.
  - Half: lanes {offset+1, offset}; data = i_data4Mem[15:0] replicated.
  - Word: all lanes.
- Load path:
  - The RAM reads the whole word synchronously.
  - Offset, width and sign are registered alongside the read.
  - Extraction and extension are combinational after the RAM register. o_read_data is valid in the same cycle as the other registered outputs.
- Read-during-write to the same word: read-first; the load returns the old contents.
- Halt: no RAM write. All MEM/WB outputs and the load-side registers hold.
- Reset:
  - o_mem2reg=0, o_regWrite=0, o_result=0, o_write_reg=0, o_misalign=0, o_read_data=0, o_dbg_data=0.
  - Memory contents are not cleared.
  - A store presented in the reset cycle is not written.
- Reset has priority over halt; halt has priority over normal update.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on all outputs after edge N; the store commits at edge N.
- A load at edge N+1 of a word stored at edge N sees the new data; no internal forwarding is needed.
- Throughput: one access per cycle, no stalls generated.
- Debug read: 1-cycle latency; o_dbg_data updates every cycle while i_halt=1 and holds while i_halt=0.

## Configuration
- MEM_DEBUG_PORT_EN defined:
  - i_dbg_addr and o_dbg_data exist.
  - While halted, the RAM read address is muxed to i_dbg_addr.
- Undefined: both ports are absent; the RAM read address always comes from i_result.
- Pipeline behaviour is identical in both builds.

## Structure
- Shared package (mem_pkg):
  - Width codes WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b11.
  - Byte-enable width constant (4).
  - Functions computing byte enables and load extraction.
- Sub-module data_memory: single-port synchronous RAM with 4 byte enables and read-first behaviour, parameterised by NB_DATA and NB_ADDR.
- mem_stage holds alignment/enable logic, the MEM/WB register and the load extractor.

## Test plan
- sw 0xDEADBEEF at 0x10, then lw 0x10 next cycle → o_read_data=0xDEADBEEF, o_misalign=0.
- sb 0x000000A5 at 0x13 over word 0x11223344, then lw 0x10 → 0xA5223344. Then lb signed 0x13 → 0xFFFFFFA5; lbu 0x13 → 0x000000A5.
- sh 0x8001 at 0x22, then lh signed 0x22 → 0xFFFF8001; lhu → 0x00008001.
- sw at 0x21 → memory unchanged (lw 0x20 returns prior value) and o_misalign=1 for one cycle. lh at 0x23 → o_read_data=0, o_misalign=1.
- Halt:
  - i_halt=1 with a store pending → no write; outputs hold 3 cycles.
  - With MEM_DEBUG_PORT_EN, i_dbg_addr=4 → o_dbg_data equals word 4 one cycle later.
- Reset mid-stream during a store cycle:
  - All outputs 0 next cycle and the store is not committed.
  - Previously stored words read back unchanged after reset.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: width codes, lane count and the
// byte-enable / store-lane / load-extraction helpers used by mem_stage.
package mem_pkg;

  localparam int NB_BE   = 4;
  localparam int NB_WORD = 32;

  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_RSVD = 2'b10,
    WIDTH_WORD = 2'b11
  } width_e;

  // Code 2'b10 behaves as a word, so bit 1 alone marks a full-word access.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (width == WIDTH_HALF) begin
      mis = offset[0];
    end else if (width[1]) begin
      mis = (offset != 2'b00);
    end
    return mis;
  endfunction

  function automatic logic [NB_BE-1:0] byte_enables(input logic [1:0] width, input logic [1:0] offset);
    logic [NB_BE-1:0] be;
    case (width)
      WIDTH_BYTE: be = 4'b0001 << offset;
      WIDTH_HALF: be = 4'b0011 << offset;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [NB_WORD-1:0] store_lanes(input logic [1:0] width, input logic [NB_WORD-1:0] data);
    logic [NB_WORD-1:0] lanes;
    case (width)
      WIDTH_BYTE: lanes = {4{data[7:0]}};
      WIDTH_HALF: lanes = {2{data[15:0]}};
      default:    lanes = data;
    endcase
    return lanes;
  endfunction

  function automatic logic [NB_WORD-1:0] extract_load(input logic [NB_WORD-1:0] word,
                                                      input logic [1:0]         width,
                                                      input logic [1:0]         offset,
                                                      input logic               sign);
    logic [NB_WORD-1:0] shifted;
    logic [NB_WORD-1:0] value;
    shifted = word >> {offset, 3'b000};
    case (width)
      WIDTH_BYTE: value = {{24{sign & shifted[7]}}, shifted[7:0]};
      WIDTH_HALF: value = {{16{sign & shifted[15]}}, shifted[15:0]};
      default:    value = word;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered, read-first output (the read returns the word before the write).
module data_memory
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_we,
  input  logic [NB_BE-1:0]   i_be,
  input  logic               i_re,
  input  logic [NB_ADDR-1:0] i_addr,
  input  logic [NB_DATA-1:0] i_wdata,
  output logic [NB_DATA-1:0] o_rdata
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [DEPTH];
  logic [NB_DATA-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < NB_BE; b++) begin
        if (i_be[b]) begin
          mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      rdata_q <= mem_q[i_addr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage plus MEM/WB register: aligned byte/half/word loads and stores.
// Optional MEM_DEBUG_PORT_EN adds a debug word readback while halted.
module mem_stage
  import mem_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 8
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_halt,
  input  logic               i_mem2reg,
  input  logic               i_memWrite,
  input  logic               i_regWrite,
  input  logic [1:0]         i_width,
  input  logic               i_sign_flag,
  input  logic [NB_DATA-1:0] i_result,
  input  logic [NB_DATA-1:0] i_data4Mem,
  input  logic [NB_REG-1:0]  i_write_reg,
  output logic               o_mem2reg,
  output logic               o_regWrite,
  output logic [NB_DATA-1:0] o_read_data,
  output logic [NB_DATA-1:0] o_result,
  output logic [NB_REG-1:0]  o_write_reg,
  output logic               o_misalign
`ifdef MEM_DEBUG_PORT_EN
  ,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB_DATA-1:0] o_dbg_data
`endif
);

  logic [1:0]         offset;
  logic [NB_ADDR-1:0] word_addr;
  logic               misalign;
  logic               ram_we;
  logic               ram_re;
  logic [NB_ADDR-1:0] ram_addr;
  logic [NB_BE-1:0]   ram_be;
  logic [NB_DATA-1:0] ram_wdata;
  logic [NB_DATA-1:0] ram_rdata;
  logic [NB_DATA-1:0] load_word;

  assign offset    = i_result[1:0];
  assign word_addr = i_result[NB_ADDR+1:2];
  assign misalign  = (i_memWrite | i_mem2reg) & is_misaligned(i_width, offset);
  assign ram_we    = i_memWrite & ~misalign & ~i_halt & ~i_reset;
  assign ram_be    = byte_enables(i_width, offset);
  assign ram_wdata = store_lanes(i_width, i_data4Mem);

  data_memory #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .clk     (clk),
    .i_we    (ram_we),
    .i_be    (ram_be),
    .i_re    (ram_re),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

`ifdef MEM_DEBUG_PORT_EN
  // The RAM output register is borrowed for debug reads while halted, so the
  // last pipeline word is parked in saved_word_q until the halt ends.
  logic               dbg_view_q;
  logic [NB_DATA-1:0] dbg_hold_q;
  logic [NB_DATA-1:0] saved_word_q;

  assign ram_addr = i_halt ? i_dbg_addr : word_addr;
  assign ram_re   = 1'b1;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      dbg_view_q <= 1'b0;
      dbg_hold_q <= '0;
    end else begin
      dbg_view_q <= i_halt;
      if (dbg_view_q) begin
        dbg_hold_q <= ram_rdata;
      end
    end
    if (!dbg_view_q) begin
      saved_word_q <= ram_rdata;
    end
  end

  assign load_word  = dbg_view_q ? saved_word_q : ram_rdata;
  assign o_dbg_data = dbg_view_q ? ram_rdata : dbg_hold_q;
`else
  assign ram_addr  = word_addr;
  assign ram_re    = ~i_halt;
  assign load_word = ram_rdata;
`endif

  logic               mem2reg_q,   mem2reg_d;
  logic               regwrite_q,  regwrite_d;
  logic [NB_DATA-1:0] result_q,    result_d;
  logic [NB_REG-1:0]  write_reg_q, write_reg_d;
  logic               misalign_q,  misalign_d;
  logic [1:0]         offset_q,    offset_d;
  logic [1:0]         width_q,     width_d;
  logic               sign_q,      sign_d;
  logic               zero_q,      zero_d;

  always_comb begin
    mem2reg_d   = mem2reg_q;
    regwrite_d  = regwrite_q;
    result_d    = result_q;
    write_reg_d = write_reg_q;
    misalign_d  = misalign_q;
    offset_d    = offset_q;
    width_d     = width_q;
    sign_d      = sign_q;
    zero_d      = zero_q;
    if (i_reset) begin
      mem2reg_d   = 1'b0;
      regwrite_d  = 1'b0;
      result_d    = '0;
      write_reg_d = '0;
      misalign_d  = 1'b0;
      offset_d    = 2'b00;
      width_d     = WIDTH_WORD;
      sign_d      = 1'b0;
      zero_d      = 1'b1;
    end else if (!i_halt) begin
      mem2reg_d   = i_mem2reg;
      regwrite_d  = i_regWrite;
      result_d    = i_result;
      write_reg_d = i_write_reg;
      misalign_d  = misalign;
      offset_d    = offset;
      width_d     = i_width;
      sign_d      = i_sign_flag;
      zero_d      = misalign;
    end
  end

  always_ff @(posedge clk) begin
    mem2reg_q   <= mem2reg_d;
    regwrite_q  <= regwrite_d;
    result_q    <= result_d;
    write_reg_q <= write_reg_d;
    misalign_q  <= misalign_d;
    offset_q    <= offset_d;
    width_q     <= width_d;
    sign_q      <= sign_d;
    zero_q      <= zero_d;
  end

  assign o_mem2reg   = mem2reg_q;
  assign o_regWrite  = regwrite_q;
  assign o_result    = result_q;
  assign o_write_reg = write_reg_q;
  assign o_misalign  = misalign_q;
  assign o_read_data = zero_q ? '0 : extract_load(load_word, width_q, offset_q, sign_q);

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-array memory model,
// with directed load/store cases followed by a randomized stream.
module tb_mem_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, halt, m2r, mw, rw, sgn;
  logic [1:0]  wid;
  logic [31:0] res, wdata;
  logic [4:0]  wreg;
  logic [7:0]  dbg_addr;

  logic        o_mem2reg, o_regWrite, o_misalign;
  logic [31:0] o_read_data, o_result, o_dbg_data;
  logic [4:0]  o_write_reg;

  mem_stage dut (
    .clk         (clk),
    .i_reset     (rst),
    .i_halt      (halt),
    .i_mem2reg   (m2r),
    .i_memWrite  (mw),
    .i_regWrite  (rw),
    .i_width     (wid),
    .i_sign_flag (sgn),
    .i_result    (res),
    .i_data4Mem  (wdata),
    .i_write_reg (wreg),
    .o_mem2reg   (o_mem2reg),
    .o_regWrite  (o_regWrite),
    .o_read_data (o_read_data),
    .o_result    (o_result),
    .o_write_reg (o_write_reg),
    .o_misalign  (o_misalign)
`ifdef MEM_DEBUG_PORT_EN
    ,
    .i_dbg_addr  (dbg_addr),
    .o_dbg_data  (o_dbg_data)
`endif
  );

`ifndef MEM_DEBUG_PORT_EN
  assign o_dbg_data = 32'h0;
`endif

  // Reference state: byte-addressed memory plus the expected MEM/WB outputs.
  logic [7:0]  mem_m [0:1023];
  logic        e_m2r, e_rw, e_mis, e_rd_chk;
  logic [31:0] e_res, e_rd, e_dbg;
  logic [4:0]  e_wreg;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mb(input int a);
    return mem_m[a & 1023];
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [1:0] w, input logic s);
    logic [31:0] v;
    if (w == 2'b00)      v = {{24{s & mb(a)[7]}}, mb(a)};
    else if (w == 2'b01) v = {{16{s & mb(a+1)[7]}}, mb(a+1), mb(a)};
    else                 v = {mb(a+3), mb(a+2), mb(a+1), mb(a)};
    return v;
  endfunction

  task automatic model_edge();
    int          a;
    logic        mis;
    a = int'(res[9:0]);
    if (rst) begin
      {e_m2r, e_rw, e_mis} = 3'b000;
      e_res = 0; e_wreg = 0; e_rd = 0; e_rd_chk = 1'b1; e_dbg = 0;
    end else if (halt) begin
      e_dbg = {mb(4*dbg_addr+3), mb(4*dbg_addr+2), mb(4*dbg_addr+1), mb(4*dbg_addr)};
    end else begin
      mis = (mw | m2r) && ((wid == 2'b01 && a[0]) || (wid[1] && a[1:0] != 2'b00));
      e_m2r = m2r; e_rw = rw; e_res = res; e_wreg = wreg; e_mis = mis;
      e_rd = mis ? 32'h0 : model_load(a, wid, sgn);
      e_rd_chk = m2r | mis;
      if (mw && !mis) begin
        mem_m[a] = wdata[7:0];
        if (wid != 2'b00) mem_m[a+1] = wdata[15:8];
        if (wid[1]) begin
          mem_m[a+2] = wdata[23:16];
          mem_m[a+3] = wdata[31:24];
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic h, input logic l, input logic s_w, input logic w_r,
                      input logic [1:0] w, input logic sg, input logic [31:0] ad,
                      input logic [31:0] d, input logic [4:0] dst, input logic [7:0] da);
    rst = r; halt = h; m2r = l; mw = s_w; rw = w_r; wid = w; sgn = sg;
    res = ad; wdata = d; wreg = dst; dbg_addr = da;
    @(posedge clk);
    model_edge();
    #1;
    chk("mem2reg",   {31'h0, o_mem2reg},  {31'h0, e_m2r});
    chk("regWrite",  {31'h0, o_regWrite}, {31'h0, e_rw});
    chk("result",    o_result,            e_res);
    chk("write_reg", {27'h0, o_write_reg}, {27'h0, e_wreg});
    chk("misalign",  {31'h0, o_misalign}, {31'h0, e_mis});
    if (e_rd_chk) chk("read_data", o_read_data, e_rd);
`ifdef MEM_DEBUG_PORT_EN
    chk("dbg_data", o_dbg_data, e_dbg);
`endif
  endtask

  task automatic st(input logic [31:0] ad, input logic [1:0] w, input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, w, 1'b0, ad, d, 5'd0, 8'd0);
  endtask

  task automatic ld(input logic [31:0] ad, input logic [1:0] w, input logic s);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, w, s, ad, 32'h0, 5'(ad[6:2]), 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem_m[i] = 8'h00;
    e_dbg = 0;

    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 32'h44, 32'h1234, 5'd9, 8'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 8'd0);
    chk("lit_reset_read", o_read_data, 32'h0);
    chk("lit_reset_result", o_result, 32'h0);

    for (int i = 0; i < 256; i++) st(32'(4 * i), 2'b11, $urandom);

    st(32'h10, 2'b11, 32'hDEADBEEF);
    ld(32'h10, 2'b11, 1'b0);
    chk("lit_lw", o_read_data, 32'hDEADBEEF);
    chk("lit_lw_mis", {31'h0, o_misalign}, 32'h0);

    st(32'h10, 2'b11, 32'h11223344);
    st(32'h13, 2'b00, 32'h000000A5);
    ld(32'h10, 2'b11, 1'b0);
    chk("lit_sb_lw", o_read_data, 32'hA5223344);
    ld(32'h13, 2'b00, 1'b1);
    chk("lit_lb", o_read_data, 32'hFFFFFFA5);
    ld(32'h13, 2'b00, 1'b0);
    chk("lit_lbu", o_read_data, 32'h000000A5);

    st(32'h22, 2'b01, 32'h00008001);
    ld(32'h22, 2'b01, 1'b1);
    chk("lit_lh", o_read_data, 32'hFFFF8001);
    ld(32'h22, 2'b01, 1'b0);
    chk("lit_lhu", o_read_data, 32'h00008001);

    st(32'h21, 2'b11, 32'h0BADF00D);
    chk("lit_sw_mis", {31'h0, o_misalign}, 32'h1);
    ld(32'h20, 2'b11, 1'b0);
    chk("lit_sw_mis_clear", {31'h0, o_misalign}, 32'h0);
    chk("lit_sw_mis_mem", {16'h0, o_read_data[31:16]}, 32'h8001);
    ld(32'h23, 2'b01, 1'b1);
    chk("lit_lh_mis_data", o_read_data, 32'h0);
    chk("lit_lh_mis", {31'h0, o_misalign}, 32'h1);

    st(32'h40, 2'b11, 32'h12345678);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'h40, 32'hCAFEF00D, 5'd3, 8'd4);
    chk("lit_halt_result", o_result, 32'h40);
`ifdef MEM_DEBUG_PORT_EN
    chk("lit_dbg_word4", o_dbg_data, 32'hA5223344);
`endif
    ld(32'h40, 2'b11, 1'b0);
    chk("lit_halt_nowrite", o_read_data, 32'h12345678);

    st(32'h50, 2'b11, 32'h01020304);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h50, 32'hFFFFFFFF, 5'd7, 8'd0);
    chk("lit_rst_regwrite", {31'h0, o_regWrite}, 32'h0);
    chk("lit_rst_read", o_read_data, 32'h0);
    ld(32'h50, 2'b11, 1'b0);
    chk("lit_rst_nostore", o_read_data, 32'h01020304);
    ld(32'h10, 2'b11, 1'b0);
    chk("lit_rst_keep", o_read_data, 32'hA5223344);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ad;
      ad = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) ad[1:0] = 2'b00;
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 2'($urandom), 1'($urandom), {22'($urandom), ad[9:0]}, $urandom,
           5'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
